// File: rtl/action_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module  : action_sequencer_if
// Brief   : Request/frame-tick handshake and ROM-address bundle for one fighter.
// Rev     : 1.0 - initial release
// ============================================================================
interface action_sequencer_if #(
   parameter int ADDR_W = 7
);
   logic              frame_tick;
   logic              req_valid;
   logic [2:0]        req_action;
   logic              req_ready;
   logic [ADDR_W-1:0] rom_addr;
   logic [2:0]        cur_action;
   logic              busy;
   logic              done;

   modport master (
      output frame_tick, req_valid, req_action,
      input  req_ready, rom_addr, cur_action, busy, done
   );

   modport slave (
      input  frame_tick, req_valid, req_action,
      output req_ready, rom_addr, cur_action, busy, done
   );
endinterface
`default_nettype wire

// File: rtl/action_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : action_sequencer
// Brief   : Steps a fighter action's frames at frame-tick rate and drives the
//           registered action-ROM address. Optional hitstop: ACTION_HITSTOP_EN.
// Rev     : 1.0 - initial release
// ============================================================================
module action_sequencer #(
   parameter int ADDR_W        = 7,
   parameter int FRAME_W       = 4,
   parameter int HOLD_TICKS    = 4,
   parameter int HITSTOP_TICKS = 6
) (
   input  wire logic           clk,
   input  wire logic           rst_n,
   action_sequencer_if.slave   bus
);
   localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam int HS_W   = (HITSTOP_TICKS > 1) ? $clog2(HITSTOP_TICKS) : 1;

   localparam logic [1:0] S_LOOP    = 2'd0;
   localparam logic [1:0] S_ONESHOT = 2'd1;
   localparam logic [1:0] S_HITSTOP = 2'd2;

   localparam logic [2:0]        c_hit       = 3'd6;
   localparam logic [2:0]        c_rsvd      = 3'd7;
   localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(HOLD_TICKS - 1);

   if ((ADDR_W != 3 + FRAME_W) || (HOLD_TICKS < 1) || (HITSTOP_TICKS < 1)) begin : g_param_check
      $error("action_sequencer: inconsistent parameters");
   end

   // Index of the final frame of each action; the reserved code never plays.
   function automatic logic [FRAME_W-1:0] f_last(input logic [2:0] act);
      case (act)
         3'd0:    f_last = FRAME_W'(3);
         3'd1:    f_last = FRAME_W'(5);
         3'd2:    f_last = FRAME_W'(5);
         3'd3:    f_last = FRAME_W'(4);
         3'd4:    f_last = FRAME_W'(5);
         3'd5:    f_last = FRAME_W'(7);
         3'd6:    f_last = FRAME_W'(2);
         default: f_last = '0;
      endcase
   endfunction

   logic [1:0]         r_state,  w_state_nxt;
   logic [2:0]         r_action, w_action_nxt;
   logic [FRAME_W-1:0] r_frame,  w_frame_nxt;
   logic [HOLD_W-1:0]  r_hold,   w_hold_nxt;
   logic [ADDR_W-1:0]  r_rom_addr;
   logic               r_busy;
   logic               r_done,   w_done_nxt;
   logic               w_req_ready;
   logic               w_accept;
`ifdef ACTION_HITSTOP_EN
   localparam logic [HS_W-1:0] c_hs_last = HS_W'(HITSTOP_TICKS - 1);
   logic [HS_W-1:0]    r_hs_cnt, w_hs_nxt;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_LOOP;
         r_action   <= '0;
         r_frame    <= '0;
         r_hold     <= '0;
         r_rom_addr <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
`ifdef ACTION_HITSTOP_EN
         r_hs_cnt   <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_action   <= w_action_nxt;
         r_frame    <= w_frame_nxt;
         r_hold     <= w_hold_nxt;
         r_rom_addr <= ADDR_W'({r_action, r_frame});
         r_busy     <= (w_state_nxt != S_LOOP);
         r_done     <= w_done_nxt;
`ifdef ACTION_HITSTOP_EN
         r_hs_cnt   <= w_hs_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_action_nxt = r_action;
      w_frame_nxt  = r_frame;
      w_hold_nxt   = r_hold;
      w_done_nxt   = 1'b0;
`ifdef ACTION_HITSTOP_EN
      w_hs_nxt     = r_hs_cnt;
`endif
      // An accepted request swallows any frame tick arriving in the same cycle.
      if (w_accept) begin
         w_action_nxt = bus.req_action;
         w_frame_nxt  = '0;
         w_hold_nxt   = '0;
         w_state_nxt  = (bus.req_action <= 3'd2) ? S_LOOP : S_ONESHOT;
`ifdef ACTION_HITSTOP_EN
         w_hs_nxt     = '0;
         if (bus.req_action == c_hit) begin
            w_state_nxt = S_HITSTOP;
         end
`endif
      end else if (bus.frame_tick) begin
`ifdef ACTION_HITSTOP_EN
         if (r_state == S_HITSTOP) begin
            if (r_hs_cnt == c_hs_last) begin
               w_hs_nxt    = '0;
               w_hold_nxt  = '0;
               w_state_nxt = S_ONESHOT;
            end else begin
               w_hs_nxt = r_hs_cnt + 1'b1;
            end
         end else
`endif
         if (r_hold == c_hold_last) begin
            w_hold_nxt = '0;
            if (r_frame == f_last(r_action)) begin
               w_frame_nxt = '0;
               if (r_state != S_LOOP) begin
                  w_done_nxt   = 1'b1;
                  w_action_nxt = '0;
                  w_state_nxt  = S_LOOP;
               end
            end else begin
               w_frame_nxt = r_frame + 1'b1;
            end
         end else begin
            w_hold_nxt = r_hold + 1'b1;
         end
      end
   end

   // HIT may always barge in; anything else only while a loop action plays.
   always_comb begin
      w_req_ready = 1'b0;
      if (bus.req_action == c_hit) begin
         w_req_ready = 1'b1;
      end else if ((r_state == S_LOOP) && (bus.req_action != c_rsvd)) begin
         w_req_ready = 1'b1;
      end
      w_accept = bus.req_valid & w_req_ready;
   end

   assign bus.req_ready  = w_req_ready;
   assign bus.rom_addr   = r_rom_addr;
   assign bus.cur_action = r_action;
   assign bus.busy       = r_busy;
   assign bus.done       = r_done;

endmodule
`default_nettype wire

// File: tb/tb_action_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_action_sequencer
// Brief   : Directed self-checking bench for action_sequencer.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_action_sequencer;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   action_sequencer_if #(.ADDR_W(7)) bus ();

   action_sequencer #(
      .ADDR_W(7), .FRAME_W(4), .HOLD_TICKS(4), .HITSTOP_TICKS(6)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int errors   = 0;
   int checks   = 0;
   int done_cnt = 0;
   logic [6:0] q_exp [$];

   always @(negedge clk) begin
      if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input bit v, input logic [2:0] a, input bit ft);
      bus.req_valid  = v;
      bus.req_action = a;
      bus.frame_tick = ft;
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
      bus.frame_tick = 1'b0;
   endtask

   // Each tick is followed by a quiet cycle so rom_addr has caught up.
   task automatic tick_n(input int n);
      for (int k = 0; k < n; k++) begin
         cyc(1'b0, 3'd0, 1'b1);
         cyc(1'b0, 3'd0, 1'b0);
      end
   endtask

   task automatic expect_addr(input logic [6:0] e);
      q_exp.push_back(e);
   endtask

   task automatic pop_addr(input string tag);
      logic [6:0] e;
      if (q_exp.size() == 0) begin
         chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = q_exp.pop_front();
         chk(tag, 32'(bus.rom_addr), 32'(e));
      end
   endtask

   initial begin
      int d0;
      bus.req_valid  = 1'b0;
      bus.req_action = 3'd0;
      bus.frame_tick = 1'b0;
      rst_n          = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      chk("rst_rom",   32'(bus.rom_addr),   32'h00);
      chk("rst_busy",  32'(bus.busy),       32'd0);
      chk("rst_done",  32'(bus.done),       32'd0);
      chk("rst_ready", 32'(bus.req_ready),  32'd1);
      chk("rst_cur",   32'(bus.cur_action), 32'd0);

      // IDLE loops through four frames.
      d0 = done_cnt;
      for (int i = 1; i <= 16; i++) begin
         expect_addr(7'((i / 4) % 4));
         tick_n(1);
         pop_addr("idle_loop");
      end
      chk("idle_no_done", 32'(done_cnt - d0), 32'd0);
      chk("idle_busy",    32'(bus.busy),      32'd0);

      // PUNCH runs to completion and returns to IDLE.
      d0 = done_cnt;
      cyc(1'b1, 3'd3, 1'b0);
      cyc(1'b0, 3'd0, 1'b0);
      expect_addr(7'h30); pop_addr("punch_start");
      chk("punch_busy", 32'(bus.busy), 32'd1);
      tick_n(19);
      expect_addr(7'h34); pop_addr("punch_last");
      chk("punch_no_done_yet", 32'(done_cnt - d0), 32'd0);
      tick_n(1);
      chk("punch_done", 32'(done_cnt - d0), 32'd1);
      expect_addr(7'h00); pop_addr("punch_end");
      chk("punch_end_busy", 32'(bus.busy),       32'd0);
      chk("punch_end_cur",  32'(bus.cur_action), 32'd0);

      // KICK ignores a WALK_F request.
      cyc(1'b1, 3'd4, 1'b0);
      tick_n(8);
      expect_addr(7'h42); pop_addr("kick_f2");
      bus.req_action = 3'd1;
      #1;
      chk("kick_ready_walk", 32'(bus.req_ready), 32'd0);
      cyc(1'b1, 3'd1, 1'b0);
      cyc(1'b0, 3'd0, 1'b0);
      expect_addr(7'h42); pop_addr("kick_hold");
      chk("kick_cur", 32'(bus.cur_action), 32'd4);
      d0 = done_cnt;
      tick_n(16);
      chk("kick_done", 32'(done_cnt - d0), 32'd1);
      expect_addr(7'h00); pop_addr("kick_end");
      chk("kick_end_cur", 32'(bus.cur_action), 32'd0);

      // HIT interrupts JUMP.
      cyc(1'b1, 3'd5, 1'b0);
      tick_n(20);
      expect_addr(7'h55); pop_addr("jump_f5");
      bus.req_action = 3'd6;
      #1;
      chk("jump_ready_hit", 32'(bus.req_ready), 32'd1);
      cyc(1'b1, 3'd6, 1'b0);
      cyc(1'b0, 3'd0, 1'b0);
      expect_addr(7'h60); pop_addr("hit_start");
      chk("hit_busy", 32'(bus.busy),       32'd1);
      chk("hit_cur",  32'(bus.cur_action), 32'd6);
      d0 = done_cnt;
`ifdef ACTION_HITSTOP_EN
      tick_n(6);
      expect_addr(7'h60); pop_addr("hitstop_frozen");
      tick_n(3);
      expect_addr(7'h60); pop_addr("hitstop_hold");
      chk("hitstop_busy", 32'(bus.busy), 32'd1);
      tick_n(1);
      expect_addr(7'h61); pop_addr("hitstop_step");
      tick_n(8);
`else
      tick_n(11);
      expect_addr(7'h62); pop_addr("hit_last");
      tick_n(1);
`endif
      chk("hit_done", 32'(done_cnt - d0), 32'd1);
      expect_addr(7'h00); pop_addr("hit_end");
      chk("hit_end_busy", 32'(bus.busy), 32'd0);

      // Request colliding with a frame advance wins and restarts WALK_B.
      cyc(1'b1, 3'd2, 1'b0);
      tick_n(7);
      expect_addr(7'h21); pop_addr("walkb_f1");
      cyc(1'b1, 3'd2, 1'b1);
      cyc(1'b0, 3'd0, 1'b0);
      expect_addr(7'h20); pop_addr("walkb_restart");
      tick_n(3);
      expect_addr(7'h20); pop_addr("walkb_hold");
      tick_n(1);
      expect_addr(7'h21); pop_addr("walkb_step");

      // Reserved code is refused.
      bus.req_action = 3'd7;
      #1;
      chk("rsvd_ready", 32'(bus.req_ready), 32'd0);
      cyc(1'b1, 3'd7, 1'b0);
      cyc(1'b0, 3'd0, 1'b0);
      expect_addr(7'h21); pop_addr("rsvd_nochange");
      chk("rsvd_cur", 32'(bus.cur_action), 32'd2);

      // Reset on the final PUNCH tick suppresses done.
      cyc(1'b1, 3'd3, 1'b0);
      tick_n(19);
      d0 = done_cnt;
      rst_n = 1'b0;
      cyc(1'b0, 3'd0, 1'b1);
      rst_n = 1'b1;
      cyc(1'b0, 3'd0, 1'b0);
      chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
      expect_addr(7'h00); pop_addr("midrst_rom");
      chk("midrst_busy", 32'(bus.busy),       32'd0);
      chk("midrst_cur",  32'(bus.cur_action), 32'd0);

      chk("sb_drained", 32'(q_exp.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
